alu_op_sequencer: RTL and testbench

- Clocked command front-end for the combinational 8-bit, 3-bit-opcode logic unit (operands A, B; control alu_control; output result).
- Accepts operand/opcode commands over a valid/ready handshake and drives the ALU inputs.
- Holds the inputs stable for a programmable settle time, then samples the ALU result.
- Returns each result, tagged with its opcode, through a small in-order response FIFO with valid/ready back-pressure.

---
 rtl/alu_op_sequencer.sv | 107 ++++++++++
 tb/tb_alu_op_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Clocked command front-end for a combinational ALU: accepts operand/opcode commands,
// holds the ALU inputs for SETTLE cycles, then queues {result, opcode} in an in-order response FIFO.
module alu_op_sequencer #(
    parameter int N      = 8,
    parameter int SETTLE = 1,   // 1..15
    parameter int DEPTH  = 4    // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [N-1:0]             cmd_a,
    input  logic [N-1:0]             cmd_b,
    input  logic [2:0]               cmd_op,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    output logic [2:0]               alu_control,
    input  logic [N-1:0]             alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [N-1:0]             rsp_result,
    output logic [2:0]               rsp_op,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, DRIVE} state_t;

    typedef struct packed {
        logic [N-1:0] result;
        logic [2:0]   op;
    } entry_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    entry_t          mem [DEPTH];

    logic accept;
    logic capture;
    logic pop;

    // Room is checked only at acceptance; one command in flight means a capture always fits.
    assign cmd_ready  = (state == IDLE) && (level < (AW+1)'(DEPTH));
    assign busy       = (state == DRIVE);
    assign accept     = cmd_valid && cmd_ready;
    assign capture    = (state == DRIVE) && (cnt == 4'd0);
    assign rsp_valid  = (level != '0);
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_result = mem[rd_ptr].result;
    assign rsp_op     = mem[rd_ptr].op;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= 3'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a       <= cmd_a;
                        alu_b       <= cmd_b;
                        alu_control <= cmd_op;
                        cnt         <= 4'(SETTLE - 1);
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Power-of-two depth lets the pointers wrap naturally.
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;

            case ({capture, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only visible through level, which is.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= '{result: alu_result, op: alu_control};
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: scoreboard of expected responses plus directed
// timing checks; the bench ALU is XOR of the operands (with an extra perturbation on the SETTLE=3 copy).
module tb_alu_op_sequencer;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SETTLE=1 instance signals
    logic          cmd_valid, cmd_ready;
    logic [N-1:0]  cmd_a, cmd_b;
    logic [2:0]    cmd_op;
    logic [N-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_control;
    logic          rsp_valid, rsp_ready;
    logic [N-1:0]  rsp_result;
    logic [2:0]    rsp_op;
    logic          busy;
    logic [LW-1:0] level;

    logic rdy_fixed, rnd_rdy, rnd_bit;
    assign rsp_ready  = rnd_rdy ? rnd_bit : rdy_fixed;
    assign alu_result = alu_a ^ alu_b;

    // SETTLE=3 instance signals
    logic          s3_cmd_valid, s3_cmd_ready;
    logic [N-1:0]  s3_cmd_a, s3_cmd_b;
    logic [2:0]    s3_cmd_op;
    logic [N-1:0]  s3_alu_a, s3_alu_b, s3_alu_result;
    logic [2:0]    s3_alu_control;
    logic          s3_rsp_valid, s3_rsp_ready;
    logic [N-1:0]  s3_rsp_result;
    logic [2:0]    s3_rsp_op;
    logic          s3_busy;
    logic [LW-1:0] s3_level;
    logic [N-1:0]  perturb3;
    assign s3_alu_result = s3_alu_a ^ s3_alu_b ^ perturb3;

    alu_op_sequencer #(.N(N), .SETTLE(1), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op),
        .busy(busy), .level(level)
    );

    alu_op_sequencer #(.N(N), .SETTLE(3), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready),
        .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_op(s3_cmd_op),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_control(s3_alu_control),
        .alu_result(s3_alu_result),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
        .rsp_result(s3_rsp_result), .rsp_op(s3_rsp_op),
        .busy(s3_busy), .level(s3_level)
    );

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: every response is the XOR of its command's operands, tagged with its opcode,
    // delivered in command order.
    typedef struct packed {
        logic [N-1:0] result;
        logic [2:0]   op;
    } exp_t;

    exp_t sb[$];

    function automatic logic [N-1:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b);
        return a ^ b;
    endfunction

    // Monitor: a response is consumed at the edge following a negedge with valid & ready.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e.result));
                check("rsp_op", 32'(rsp_op), 32'(e.op));
            end
        end
    end

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    int unsigned acc_cyc;

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Must be called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        bit accepted = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        #1;
        acc_cyc = cyc;
        if (accepted) sb.push_back('{result: ref_alu(a, b), op: op});
        cmd_valid = 1'b0;
    endtask

    task automatic wait_level(input int target, input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (int'(level) == target) break;
        end
        check(name, 32'(level), 32'(target));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && level == '0) break;
        end
        check({name, "_level"}, 32'(level), 32'd0);
        check({name, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned prev;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        rdy_fixed = 1'b0; rnd_rdy = 1'b0;
        s3_cmd_valid = 1'b0; s3_cmd_a = '0; s3_cmd_b = '0; s3_cmd_op = '0;
        s3_rsp_ready = 1'b1; perturb3 = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s3_level", 32'(s3_level), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        align();

        // SETTLE=3: result must be sampled exactly at E0+3
        s3_cmd_a = 8'h3C; s3_cmd_b = 8'h0F; s3_cmd_op = 3'd6; s3_cmd_valid = 1'b1;
        perturb3 = 8'h5A;
        @(negedge clk);
        check("s3_cmd_ready", 32'(s3_cmd_ready), 32'd1);
        @(posedge clk);            // E0
        #1 s3_cmd_valid = 1'b0;
        @(negedge clk);
        check("s3_alu_a_e0", 32'(s3_alu_a), 32'h3C);
        check("s3_busy_c1", 32'(s3_busy), 32'd1);
        @(posedge clk);            // E0+1
        @(negedge clk);
        check("s3_busy_c2", 32'(s3_busy), 32'd1);
        check("s3_level_c2", 32'(s3_level), 32'd0);
        @(posedge clk);            // E0+2
        #1 perturb3 = 8'hA5;
        @(negedge clk);
        check("s3_busy_c3", 32'(s3_busy), 32'd1);
        check("s3_alu_b_c3", 32'(s3_alu_b), 32'h0F);
        check("s3_level_c3", 32'(s3_level), 32'd0);
        @(posedge clk);            // E0+3: capture
        @(negedge clk);
        check("s3_busy_done", 32'(s3_busy), 32'd0);
        check("s3_rsp_valid", 32'(s3_rsp_valid), 32'd1);
        check("s3_rsp_result", 32'(s3_rsp_result), 32'(8'h3C ^ 8'h0F ^ 8'hA5));
        check("s3_rsp_op", 32'(s3_rsp_op), 32'd6);
        check("s3_alu_control_hold", 32'(s3_alu_control), 32'd6);
        @(negedge clk);
        check("s3_level_popped", 32'(s3_level), 32'd0);

        // Single op, SETTLE=1
        align();
        rdy_fixed = 1'b0;
        send(8'hF6, 8'h0A, 3'd0);
        @(negedge clk);
        check("single_alu_a", 32'(alu_a), 32'hF6);
        check("single_alu_b", 32'(alu_b), 32'h0A);
        check("single_busy", 32'(busy), 32'd1);
        check("single_rsp_valid_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_level", 32'(level), 32'd1);
        check("single_busy_done", 32'(busy), 32'd0);
        check("single_alu_a_hold", 32'(alu_a), 32'hF6);
        @(posedge clk);
        #1 rdy_fixed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("single_level_popped", 32'(level), 32'd0);
        rdy_fixed = 1'b0;

        // Back-pressure fill and ordered drain
        align();
        send(8'h0F, 8'h22, 3'd1);
        send(8'd33, 8'd55, 3'd2);
        send(8'd2,  8'd1,  3'd3);
        send(8'hF6, 8'h0A, 3'd4);
        cmd_a = 8'h5A; cmd_b = 8'h3C; cmd_op = 3'd5; cmd_valid = 1'b1;
        @(negedge clk);
        check("fill_ready_busy", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("fill_level_full", 32'(level), 32'd4);
        check("fill_ready_full", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 rdy_fixed = 1'b1;
        @(negedge clk);
        check("fill_ready_before_pop", 32'(cmd_ready), 32'd0);
        @(posedge clk);            // first pop
        @(negedge clk);
        check("fill_ready_after_pop", 32'(cmd_ready), 32'd1);
        check("fill_level_after_pop", 32'(level), 32'd3);
        @(posedge clk);            // fifth command accepted
        #1;
        sb.push_back('{result: ref_alu(8'h5A, 8'h3C), op: 3'd5});
        cmd_valid = 1'b0;
        wait_drain("fill_drain");

        // Capture and pop on the same edge
        rdy_fixed = 1'b0;
        align();
        send(8'h11, 8'h22, 3'd1);
        wait_level(1, "cp_setup_level");
        align();
        send(8'h44, 8'h18, 3'd7);
        rdy_fixed = 1'b1;
        @(negedge clk);
        check("cp_level_before", 32'(level), 32'd1);
        @(negedge clk);
        check("cp_level_after", 32'(level), 32'd1);
        check("cp_head_result", 32'(rsp_result), 32'(ref_alu(8'h44, 8'h18)));
        check("cp_head_op", 32'(rsp_op), 32'd7);
        wait_drain("cp_drain");

        // Reset while a command is in DRIVE with two responses queued
        rdy_fixed = 1'b0;
        align();
        send(8'hA1, 8'h01, 3'd2);
        send(8'hB2, 8'h02, 3'd3);
        wait_level(2, "rst_mid_setup_level");
        align();
        send(8'hC3, 8'h03, 3'd4);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_alu_a", 32'(alu_a), 32'd0);
        check("rst_mid_alu_control", 32'(alu_control), 32'd0);
        check("rst_mid_level", 32'(level), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_no_write_level", 32'(level), 32'd0);
        check("rst_mid_no_write_valid", 32'(rsp_valid), 32'd0);
        align();
        send(8'h81, 8'h7E, 3'd2);
        wait_level(1, "rst_mid_next_level");
        rdy_fixed = 1'b1;
        wait_drain("rst_mid_drain");

        // Streaming opcode sweep: one accept every SETTLE+1 = 2 cycles
        rdy_fixed = 1'b1;
        align();
        prev = 0;
        for (int op = 0; op < 8; op++) begin
            send(8'($urandom), 8'($urandom), 3'(op));
            if (op > 0) check("stream_spacing", acc_cyc - prev, 32'd2);
            prev = acc_cyc;
        end
        wait_drain("stream_drain");

        // Randomized traffic with random consumer back-pressure
        rnd_rdy = 1'b1;
        align();
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom));
            repeat ($urandom_range(0, 2)) align();
        end
        rnd_rdy = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
